// File: rtl/sandik_sayim.sv
// Ballot-box vote counter: tallies T/H votes for four boxes into packed 2-bit
// saturating slices under a start/close session protocol with an idle timeout.
module sandik_sayim #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       close,
  input  logic       vote_valid,
  input  logic [1:0] box_sel,
  input  logic       vote,
  output logic       vote_ready,
  output logic [7:0] T,
  output logic [7:0] H,
  output logic       done,
  output logic       ovf
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] IdleLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCounting,
    StClosed
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] idle_q;
  logic [7:0]      t_q;
  logic [7:0]      h_q;
  logic            ovf_q;

  logic            accept;
  logic [2:0]      slice_lsb;
  logic [1:0]      sel_slice;
  logic            sel_sat;
  logic [7:0]      t_d;
  logic [7:0]      h_d;
  logic            timeout_hit;

  assign vote_ready  = (state_q == StCounting);
  assign done        = (state_q == StClosed);
  assign T           = t_q;
  assign H           = h_q;
  assign ovf         = ovf_q;

  assign accept      = vote_valid && vote_ready;
  assign slice_lsb   = {box_sel, 1'b0};
  assign sel_slice   = vote ? t_q[slice_lsb +: 2] : h_q[slice_lsb +: 2];
  assign sel_sat     = (sel_slice == 2'b11);
  assign timeout_hit = !accept && (idle_q == IdleLast);

  // Only the selected slice moves; a saturated slice stays at 3.
  always_comb begin
    t_d = t_q;
    h_d = h_q;
    if (accept && !sel_sat) begin
      if (vote) begin
        t_d[slice_lsb +: 2] = sel_slice + 2'd1;
      end else begin
        h_d[slice_lsb +: 2] = sel_slice + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idle_q  <= '0;
      t_q     <= 8'h00;
      h_q     <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StClosed: begin
          if (start) begin
            state_q <= StCounting;
            idle_q  <= '0;
            t_q     <= 8'h00;
            h_q     <= 8'h00;
            ovf_q   <= 1'b0;
          end
        end
        StCounting: begin
          t_q <= t_d;
          h_q <= h_d;
          if (accept && sel_sat) begin
            ovf_q <= 1'b1;
          end
          if (accept) begin
            idle_q <= '0;
          end else begin
            idle_q <= idle_q + CntW'(1);
          end
          // A vote arriving with close is still counted on this edge.
          if (close || timeout_hit) begin
            state_q <= StClosed;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sandik_sayim.sv
// Directed self-checking bench for sandik_sayim with TIMEOUT = 16.
module tb_sandik_sayim;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic       start;
  logic       close;
  logic       vote_valid;
  logic [1:0] box_sel;
  logic       vote;
  logic       vote_ready;
  logic [7:0] T;
  logic [7:0] H;
  logic       done;
  logic       ovf;

  int n_cmp;
  int n_err;

  sandik_sayim #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .close     (close),
    .vote_valid(vote_valid),
    .box_sel   (box_sel),
    .vote      (vote),
    .vote_ready(vote_ready),
    .T         (T),
    .H         (H),
    .done      (done),
    .ovf       (ovf)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
    else clk = 1'b0;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_vote(input logic [1:0] b, input logic v);
    vote_valid = 1'b1;
    box_sel    = b;
    vote       = v;
    cycle();
    vote_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic do_close();
    close = 1'b1;
    cycle();
    close = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    n_cmp++; if (T !== 8'h00) begin n_err++; $display("FAIL reset_T got %h want 00", T); end
    n_cmp++; if (H !== 8'h00) begin n_err++; $display("FAIL reset_H got %h want 00", H); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (vote_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready got %b want 0", vote_ready);
    end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
    vote_valid = 1'b1;
    vote       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      box_sel = 2'(i);
      cycle();
    end
    vote_valid = 1'b0;
    n_cmp++; if (T !== 8'h00) begin n_err++; $display("FAIL idle_vote_T got %h want 00", T); end
    n_cmp++; if (H !== 8'h00) begin n_err++; $display("FAIL idle_vote_H got %h want 00", H); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL idle_vote_ovf got %b want 0", ovf); end
  endtask

  task automatic test_basic_tally();
    do_start();
    n_cmp++; if (vote_ready !== 1'b1) begin
      n_err++; $display("FAIL basic_ready got %b want 1", vote_ready);
    end
    do_vote(2'd0, 1'b1);
    do_vote(2'd0, 1'b1);
    do_vote(2'd1, 1'b0);
    do_vote(2'd3, 1'b1);
    n_cmp++; if (T !== 8'b01_00_00_10) begin n_err++; $display("FAIL basic_T got %h want 42", T); end
    n_cmp++; if (H !== 8'b00_00_01_00) begin n_err++; $display("FAIL basic_H got %h want 04", H); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pre got %b want 0", done); end
    do_close();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done got %b want 1", done); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL basic_ovf got %b want 0", ovf); end
    n_cmp++; if (vote_ready !== 1'b0) begin
      n_err++; $display("FAIL basic_ready_closed got %b want 0", vote_ready);
    end
  endtask

  task automatic test_saturation();
    do_start();
    for (int i = 0; i < 3; i++) do_vote(2'd2, 1'b1);
    n_cmp++; if (T !== 8'h30) begin n_err++; $display("FAIL sat3_T got %h want 30", T); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL sat3_ovf got %b want 0", ovf); end
    do_vote(2'd2, 1'b1);
    n_cmp++; if (T !== 8'h30) begin n_err++; $display("FAIL sat4_T got %h want 30", T); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL sat4_ovf got %b want 1", ovf); end
    do_vote(2'd2, 1'b1);
    n_cmp++; if (T !== 8'h30) begin n_err++; $display("FAIL sat5_T got %h want 30", T); end
    n_cmp++; if (H !== 8'h00) begin n_err++; $display("FAIL sat5_H got %h want 00", H); end
    do_close();
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL sat_ovf_closed got %b want 1", ovf); end
    do_start();
    n_cmp++; if (T !== 8'h00) begin n_err++; $display("FAIL sat_restart_T got %h want 00", T); end
    n_cmp++; if (ovf !== 1'b0) begin
      n_err++; $display("FAIL sat_restart_ovf got %b want 0", ovf);
    end
  endtask

  // Entered with a fresh COUNTING session and all tallies zero.
  task automatic test_close_with_vote();
    close = 1'b1;
    do_vote(2'd1, 1'b1);
    close = 1'b0;
    n_cmp++; if (T !== 8'h04) begin n_err++; $display("FAIL cv_T got %h want 04", T); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL cv_done got %b want 1", done); end
    n_cmp++; if (vote_ready !== 1'b0) begin
      n_err++; $display("FAIL cv_ready got %b want 0", vote_ready);
    end
    do_vote(2'd1, 1'b1);
    n_cmp++; if (T !== 8'h04) begin n_err++; $display("FAIL cv_late_T got %h want 04", T); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL cv_late_ovf got %b want 0", ovf); end
  endtask

  task automatic test_timeout();
    int n;
    do_start();
    do_vote(2'd0, 1'b1);
    n = 0;
    while (!done && n < 40) begin
      cycle();
      n++;
    end
    n_cmp++; if (n !== 16) begin n_err++; $display("FAIL to_cycles got %0d want 16", n); end
    do_start();
    do_vote(2'd0, 1'b1);
    for (int i = 0; i < 9; i++) cycle();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL to_early_done got %b want 0", done); end
    do_vote(2'd0, 1'b1);
    n = 0;
    while (!done && n < 40) begin
      cycle();
      n++;
    end
    n_cmp++; if (n !== 16) begin n_err++; $display("FAIL to_restart_cycles got %0d want 16", n); end
    n_cmp++; if (T !== 8'h02) begin n_err++; $display("FAIL to_T got %h want 02", T); end
  endtask

  task automatic test_restart();
    do_start();
    for (int i = 0; i < 3; i++) do_vote(2'd3, 1'b1);
    for (int i = 0; i < 3; i++) do_vote(2'd0, 1'b1);
    do_close();
    n_cmp++; if (T !== 8'hC3) begin n_err++; $display("FAIL rs_T got %h want c3", T); end
    do_vote(2'd1, 1'b0);
    cycle();
    cycle();
    n_cmp++; if (T !== 8'hC3) begin n_err++; $display("FAIL rs_hold_T got %h want c3", T); end
    n_cmp++; if (H !== 8'h00) begin n_err++; $display("FAIL rs_hold_H got %h want 00", H); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rs_hold_done got %b want 1", done); end
    do_start();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rs_done got %b want 0", done); end
    n_cmp++; if (T !== 8'h00) begin n_err++; $display("FAIL rs_T_clr got %h want 00", T); end
    n_cmp++; if (vote_ready !== 1'b1) begin
      n_err++; $display("FAIL rs_ready got %b want 1", vote_ready);
    end
    do_vote(2'd2, 1'b0);
    do_start();
    n_cmp++; if (H !== 8'h10) begin n_err++; $display("FAIL rs_cnt_start_H got %h want 10", H); end
    n_cmp++; if (vote_ready !== 1'b1) begin
      n_err++; $display("FAIL rs_cnt_start_ready got %b want 1", vote_ready);
    end
  endtask

  // Entered mid-session with H = 8'h10.
  task automatic test_async_reset();
    do_vote(2'd3, 1'b1);
    @(negedge clk);
    clk_en = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (T !== 8'h00) begin n_err++; $display("FAIL ar_T got %h want 00", T); end
    n_cmp++; if (H !== 8'h00) begin n_err++; $display("FAIL ar_H got %h want 00", H); end
    n_cmp++; if (vote_ready !== 1'b0) begin
      n_err++; $display("FAIL ar_ready got %b want 0", vote_ready);
    end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL ar_done got %b want 0", done); end
    #3;
    rst    = 1'b0;
    clk_en = 1'b1;
    cycle();
    n_cmp++; if (vote_ready !== 1'b0) begin
      n_err++; $display("FAIL ar_idle_ready got %b want 0", vote_ready);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    clk        = 1'b0;
    clk_en     = 1'b1;
    rst        = 1'b1;
    start      = 1'b0;
    close      = 1'b0;
    vote_valid = 1'b0;
    box_sel    = 2'd0;
    vote       = 1'b0;
    test_reset();
    test_basic_tally();
    test_saturation();
    test_close_with_vote();
    test_timeout();
    test_restart();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sandik_sayim.md
Name: sandik_sayim

Overview:
- Vote-collection front end for the election decision logic: counts per-ballot-box votes as they arrive and presents the packed 8-bit T and H tallies consumed by the election decision block.
- Four boxes with fixed slice mapping: box 0 = kirmizi T/H[1:0], box 1 = mavi [3:2], box 2 = beyaz2 [5:4], box 3 = beyaz1 [7:6].
- Runs a counting session under a start/close protocol with a ready/valid vote handshake. Raises done once tallies are final and held stable for the decision logic.

Parameters:
- TIMEOUT, 16: cycles in COUNTING with no accepted vote before an automatic close; legal range 2..65535.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a new session (accepted in IDLE or CLOSED only)
- close  input  1  end the current session (accepted in COUNTING only)
- vote_valid  input  1  a vote is presented this cycle
- box_sel  input  2  target box index 0..3
- vote  input  1  1 = vote for T, 0 = vote for H
- vote_ready  output  1  block accepts a vote this cycle
- T  output  8  packed T tallies, 2 bits per box
- H  output  8  packed H tallies, 2 bits per box
- done  output  1  session closed; T/H are final
- ovf  output  1  sticky flag: a vote hit a saturated counter this session

Behaviour:
- One clock domain; rst is asynchronous and active-high.
- Reset value of every output and register:
  - state = IDLE
  - T = 8'h00, H = 8'h00
  - done = 0, vote_ready = 0, ovf = 0
  - idle counter = 0
- Reset asserted mid-session aborts the session immediately with no clock edge required.
- States: IDLE, COUNTING, CLOSED.
- Transitions:
  - IDLE + start -> COUNTING. T, H, ovf and the idle counter are cleared on the same edge.
  - COUNTING + close -> CLOSED.
  - COUNTING + idle counter reaching TIMEOUT-1 with no accepted vote that cycle -> CLOSED.
  - CLOSED + start -> COUNTING, with the same clearing as IDLE + start.
  - start in COUNTING is ignored. close in IDLE or CLOSED is ignored.
- vote_ready = 1 exactly when state == COUNTING. It is a combinational decode of the state register.
- Vote acceptance: vote_valid && vote_ready at a rising edge.
  - The slice of the selected box in T (vote=1) or H (vote=0) increments by 1 on that edge.
  - Tallies are visible from the following cycle. Latency from accept to output update is 1 cycle.
  - At most one vote is accepted per cycle. The other seven slices are unchanged.
- Saturation: each 2-bit slice saturates at 3 and never wraps to 0. A vote to a slice already at 3 leaves it at 3 and sets ovf, which stays set until the next start or rst.
- close and an accepted vote in the same cycle: the vote is counted, and the state moves to CLOSED on that same edge.
- Idle counter:
  - Cleared on every accepted vote and on entry to COUNTING.
  - Otherwise increments each COUNTING cycle.
  - Width is the minimum needed to hold TIMEOUT-1.
- done = 1 exactly when state == CLOSED (registered via the state). It drops on the edge where start is accepted.
- T and H:
  - Driven directly from the tally registers, never combinationally from the inputs.
  - Show live counts during COUNTING.
  - Held constant throughout CLOSED.
  - Retain their last values in IDLE; after reset these are zero.
- Votes presented outside COUNTING are dropped silently, with no tally change and no ovf.
- Implementation size: state register, 8 two-bit saturating counters, the idle counter and decode. Expected 120-250 lines of RTL.

Test Plan:
- Reset/idle: assert rst mid-cycle with clock stopped -> T=H=8'h00, done=0, vote_ready=0 immediately. Drive vote_valid=1 in IDLE for 5 cycles -> T/H remain 8'h00.
- Basic tally: start, then votes {box0 T, box0 T, box1 H, box3 T}, then close -> T=8'b01_00_00_10, H=8'b00_00_01_00, done=1 one cycle after close, ovf=0.
- Saturation: 5 T-votes to box 2 -> T[5:4]=2'b11 and ovf=1 after the 4th vote. A following start clears T to 8'h00 and ovf to 0.
- Simultaneous close+vote: vote box1 T with close in the same cycle -> T[3:2]=2'b01 and state CLOSED on the same edge. A vote the next cycle is ignored; vote_ready=0.
- Timeout: TIMEOUT=16; start, one vote, then idle -> done rises 16 cycles after the last accepted vote. A vote at idle-cycle 10 restarts the count.
- Restart from CLOSED: in CLOSED with T=8'hC3, pulse start -> done=0, T=H=8'h00, vote_ready=1 the next cycle. A start pulse while COUNTING leaves tallies untouched.
